// File: rtl/scope_pkg.sv
// scope_pkg: shared definitions for the scope capture stage.
//   state_t     - capture FSM encoding (also driven out on the state port)
//   MODE_*      - trig_mode encodings; value 3 is reserved and behaves as normal
//   to_screen() - signed 8-bit sample to offset-binary screen value
package scope_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [1:0] MODE_AUTO   = 2'd0;
    localparam logic [1:0] MODE_NORMAL = 2'd1;
    localparam logic [1:0] MODE_SINGLE = 2'd2;

    // Flipping the sign bit turns two's complement into offset binary:
    // -128 -> 0x00, 0 -> 0x80, +127 -> 0xFF.
    function automatic logic [7:0] to_screen(input logic signed [7:0] s8);
        return {~s8[7], s8[6:0]};
    endfunction

endpackage

// File: rtl/scope_dpram.sv
// scope_dpram: simple dual-port trace RAM, one write port and one registered
// read port on the same clock, written so it maps onto block RAM.
//   sysclk         - clock
//   reset          - sync active-high, clears only the read register
//   we/waddr/wdata - write port, address is {bank, offset}
//   raddr/rdata    - read port, rdata valid one cycle after raddr
module scope_dpram
    import scope_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W:0]   waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W:0]   raddr,
    output logic [7:0]        rdata
);

    // Sized to the full {bank, offset} space so the bank bit can be used
    // directly as the address MSB; offsets >= DEPTH are simply never written.
    logic [7:0] mem [0:(2**(ADDR_W+1))-1];

    always_ff @(posedge sysclk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/scope_capture.sv
// scope_capture: triggered sample capture between the I2S receiver and the
// VGA waveform renderer. Selects a channel, decimates, waits for a
// level/slope trigger (or an auto timeout) and records DEPTH samples into the
// back bank of a ping-pong RAM. Banks swap only during vblank.
//   sysclk, reset            - clock, sync active-high reset
//   sampleclk                - frame strobe from the receiver (asynchronous)
//   sndCapL/sndCapR          - 24-bit signed samples, top byte is used
//   ch_sel                   - 0 left, 1 right
//   trig_level/trig_slope    - signed threshold, 0 rising / 1 falling
//   trig_mode/arm            - auto/normal/single, arm starts a single shot
//   decim                    - keep 1 of every decim+1 samples
//   vblank                   - renderer vertical blank
//   rd_addr/rd_data          - front-bank read port, 1-cycle latency
//   state                    - FSM state
//   frame_ready              - one-cycle pulse on bank swap
//   auto_fired               - last swapped trace was forced by auto mode
module scope_capture
    import scope_pkg::*;
#(
    parameter int DEPTH   = 640,
    parameter int ADDR_W  = 10,
    parameter int AUTO_TO = 1024
) (
    input  logic                sysclk,
    input  logic                reset,
    input  logic                sampleclk,
    input  logic signed [23:0]  sndCapL,
    input  logic signed [23:0]  sndCapR,
    input  logic                ch_sel,
    input  logic signed [7:0]   trig_level,
    input  logic                trig_slope,
    input  logic [1:0]          trig_mode,
    input  logic                arm,
    input  logic [3:0]          decim,
    input  logic                vblank,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [7:0]          rd_data,
    output logic [1:0]          state,
    output logic                frame_ready,
    output logic                auto_fired
);

    localparam int TCNT_W = $clog2(AUTO_TO);

    logic                 sclk_p0, sclk_p1, sclk_p2, vld_p3;
    logic signed [7:0]    s8_p3;
    logic signed [7:0]    prev;
    logic                 prev_valid, auto_flag, front;
    logic [3:0]           dcnt;
    logic [TCNT_W-1:0]    tcnt;
    logic [ADDR_W-1:0]    wptr, waddr_l;
    logic                 acc, rise, fall, trig_hit, auto_hit, enter_armed;
    logic                 we, swap;
    state_t               st, st_nxt;

    // Only the top byte of each sample reaches the screen.
    logic unused_lsb;
    assign unused_lsb = ^{sndCapL[15:0], sndCapR[15:0]};

    // ---- p0..p2: synchronizer and edge history; p3: strobe and sample ----
    always_ff @(posedge sysclk) begin
        if (reset) begin
            sclk_p0 <= 1'b0;
            sclk_p1 <= 1'b0;
            sclk_p2 <= 1'b0;
            vld_p3  <= 1'b0;
        end else begin
            sclk_p0 <= sampleclk;
            sclk_p1 <= sclk_p0;
            sclk_p2 <= sclk_p1;
            vld_p3  <= sclk_p1 & ~sclk_p2;
        end
    end

    // Receiver holds its words long after sampleclk rises, so latching on the
    // synchronized edge is safe without a data synchronizer.
    always_ff @(posedge sysclk) begin
        if (sclk_p1 & ~sclk_p2) begin
            s8_p3 <= ch_sel ? sndCapR[23:16] : sndCapL[23:16];
        end
    end

    // ---- p3: decimation, trigger evaluation, RAM write ----
    assign acc      = vld_p3 && (dcnt == 4'd0);
    assign rise     = (prev < trig_level) && (s8_p3 >= trig_level);
    assign fall     = (prev > trig_level) && (s8_p3 <= trig_level);
    assign trig_hit = acc && prev_valid && (trig_slope ? fall : rise);
    assign auto_hit = acc && (trig_mode == MODE_AUTO) &&
                      (tcnt == TCNT_W'(AUTO_TO - 1));

    always_comb begin
        st_nxt  = st;
        we      = 1'b0;
        waddr_l = wptr;
        swap    = 1'b0;
        unique case (st)
            ST_IDLE: begin
                if (trig_mode != MODE_SINGLE || arm) begin
                    st_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (trig_hit || auto_hit) begin
                    st_nxt  = ST_CAPTURE;
                    we      = 1'b1;
                    waddr_l = '0;
                end
            end
            ST_CAPTURE: begin
                if (acc) begin
                    we = 1'b1;
                    if (wptr == ADDR_W'(DEPTH - 1)) begin
                        st_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (vblank) begin
                    swap   = 1'b1;
                    st_nxt = (trig_mode == MODE_SINGLE) ? ST_IDLE : ST_ARMED;
                end
            end
            default: st_nxt = ST_IDLE;
        endcase
    end

    assign enter_armed = (st_nxt == ST_ARMED) && (st != ST_ARMED);

    always_ff @(posedge sysclk) begin
        if (reset) begin
            st <= ST_IDLE;
        end else begin
            st <= st_nxt;
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            dcnt        <= '0;
            tcnt        <= '0;
            wptr        <= '0;
            prev_valid  <= 1'b0;
            auto_flag   <= 1'b0;
            front       <= 1'b0;
            frame_ready <= 1'b0;
            auto_fired  <= 1'b0;
        end else begin
            frame_ready <= swap;
            if (swap) begin
                front      <= ~front;
                auto_fired <= auto_flag;
            end
            if (enter_armed) begin
                dcnt       <= '0;
                tcnt       <= '0;
                prev_valid <= 1'b0;
            end else begin
                // >= rather than == so a smaller decim written mid-count
                // still wraps instead of running to 15.
                if (vld_p3) begin
                    dcnt <= (dcnt >= decim) ? 4'd0 : dcnt + 4'd1;
                end
                if (acc) begin
                    prev_valid <= 1'b1;
                    if (st == ST_ARMED) begin
                        tcnt <= tcnt + TCNT_W'(1);
                    end
                end
            end
            if (st == ST_ARMED && st_nxt == ST_CAPTURE) begin
                wptr      <= ADDR_W'(1);
                auto_flag <= ~trig_hit;
            end else if (st == ST_CAPTURE && acc) begin
                wptr <= wptr + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge sysclk) begin
        if (acc) begin
            prev <= s8_p3;
        end
    end

    scope_dpram #(.ADDR_W(ADDR_W)) u_ram (
        .sysclk (sysclk),
        .reset  (reset),
        .we     (we),
        .waddr  ({~front, waddr_l}),
        .wdata  (to_screen(s8_p3)),
        .raddr  ({front, rd_addr}),
        .rdata  (rd_data)
    );

    assign state = st;

endmodule

// File: tb/tb_scope_capture.sv
module tb_scope_capture;

    localparam int DEPTH  = 640;
    localparam int ADDR_W = 10;

    logic                sysclk = 1'b0;
    logic                reset = 1'b1;
    logic                sampleclk = 1'b0;
    logic signed [23:0]  sndCapL = '0;
    logic signed [23:0]  sndCapR = '0;
    logic                ch_sel = 1'b0;
    logic signed [7:0]   trig_level = '0;
    logic                trig_slope = 1'b0;
    logic [1:0]          trig_mode = 2'd1;
    logic                arm = 1'b0;
    logic [3:0]          decim = '0;
    logic                vblank = 1'b0;
    logic [ADDR_W-1:0]   rd_addr = '0;
    logic [7:0]          rd_data;
    logic [1:0]          state;
    logic                frame_ready;
    logic                auto_fired;

    int vectors = 0;
    int miscompares = 0;
    int pulses;
    logic [7:0] sb[$];

    scope_capture #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .AUTO_TO(1024)) dut (
        .sysclk      (sysclk),
        .reset       (reset),
        .sampleclk   (sampleclk),
        .sndCapL     (sndCapL),
        .sndCapR     (sndCapR),
        .ch_sel      (ch_sel),
        .trig_level  (trig_level),
        .trig_slope  (trig_slope),
        .trig_mode   (trig_mode),
        .arm         (arm),
        .decim       (decim),
        .vblank      (vblank),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .state       (state),
        .frame_ready (frame_ready),
        .auto_fired  (auto_fired)
    );

    always #5 sysclk = ~sysclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One receiver frame: words change with sampleclk rising, held 6 cycles.
    task automatic frame(input logic [7:0] l, input logic [7:0] r);
        sndCapL   = {l, 16'($urandom)};
        sndCapR   = {r, 16'($urandom)};
        sampleclk = 1'b1;
        repeat (3) @(negedge sysclk);
        sampleclk = 1'b0;
        repeat (3) @(negedge sysclk);
    endtask

    // kind 0: left ramp from -64 upward; kind 1: left constant 0x10;
    // kind 2: left parked at -100, right ramp from +64 downward.
    // Frames pfrom, pfrom+step, ... (DEPTH of them) are expected in the trace.
    task automatic feed(input int kind, input int nfr, input int pfrom, input int step);
        for (int n = 0; n < nfr; n++) begin
            logic [7:0] l, r, sel;
            case (kind)
                0:       begin l = 8'(n - 64); r = 8'($urandom); end
                1:       begin l = 8'h10;      r = 8'($urandom); end
                default: begin l = 8'h9C;      r = 8'(64 - n);   end
            endcase
            sel = (kind == 2) ? r : l;
            if (pfrom >= 0 && n >= pfrom && (n - pfrom) % step == 0 &&
                (n - pfrom) / step < DEPTH) begin
                sb.push_back(sel + 8'h80);
            end
            frame(l, r);
        end
    endtask

    task automatic wait_state(input logic [1:0] target, input int budget, input string tag);
        int i = 0;
        while (state !== target && i < budget) begin
            @(negedge sysclk);
            i++;
        end
        check(tag, 32'(state), 32'(target));
    endtask

    task automatic swap_read(input string tag, input logic exp_auto);
        int np = 0;
        vblank = 1'b1;
        repeat (8) begin
            @(negedge sysclk);
            if (frame_ready) np++;
        end
        vblank = 1'b0;
        check({tag, "_pulses"}, 32'(np), 32'(1));
        check({tag, "_auto"}, 32'(auto_fired), 32'(exp_auto));
        check({tag, "_sbsize"}, 32'(sb.size()), 32'(DEPTH));
        for (int k = 0; k < DEPTH; k++) begin
            logic [7:0] e;
            rd_addr = k[ADDR_W-1:0];
            @(negedge sysclk);
            e = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
            check($sformatf("%s_a%0d", tag, k), 32'(rd_data), 32'(e));
        end
        sb.delete();
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        @(negedge sysclk);
        check({tag, "_state"}, 32'(state), 32'(0));
        check({tag, "_rd"}, 32'(rd_data), 32'(0));
        check({tag, "_fr"}, 32'(frame_ready), 32'(0));
        check({tag, "_af"}, 32'(auto_fired), 32'(0));
        @(negedge sysclk);
        reset = 1'b0;
    endtask

    initial begin
        // Rising trigger, normal mode, left ramp
        trig_mode = 2'd1; trig_level = 8'sd0; trig_slope = 1'b0; decim = 4'd0; ch_sel = 1'b0;
        do_reset("rst1");
        @(negedge sysclk);
        check("armed1", 32'(state), 32'(1));
        feed(0, 704, 64, 1);
        wait_state(2'd3, 20, "done_ramp");
        swap_read("ramp", 1'b0);

        // Auto timeout with constant input below the level
        trig_mode = 2'd0; trig_level = 8'sh40;
        do_reset("rst2");
        feed(1, 1663, 1023, 1);
        wait_state(2'd3, 20, "done_auto");
        swap_read("auto", 1'b1);

        // Single shot, twice
        trig_mode = 2'd2; trig_level = 8'sd0;
        do_reset("rst3");
        repeat (4) @(negedge sysclk);
        check("single_idle", 32'(state), 32'(0));
        arm = 1'b1; @(negedge sysclk); arm = 1'b0;
        check("single_armed", 32'(state), 32'(1));
        feed(0, 704, 64, 1);
        wait_state(2'd3, 20, "done_single1");
        swap_read("single1", 1'b0);
        check("single_back_idle", 32'(state), 32'(0));
        trig_level = 8'sd16;
        arm = 1'b1; @(negedge sysclk); arm = 1'b0;
        check("single_rearmed", 32'(state), 32'(1));
        feed(0, 720, 80, 1);
        wait_state(2'd3, 20, "done_single2");
        swap_read("single2", 1'b0);
        check("single_idle2", 32'(state), 32'(0));

        // Decimation by 4, swap held off by vblank
        trig_mode = 2'd1; trig_level = 8'sd0; decim = 4'd3;
        do_reset("rst4");
        feed(0, 2621, 64, 4);
        wait_state(2'd3, 20, "done_decim");
        pulses = 0;
        repeat (2000) begin
            @(negedge sysclk);
            if (frame_ready) pulses++;
        end
        check("decim_noswap", 32'(pulses), 32'(0));
        check("decim_hold_done", 32'(state), 32'(3));
        swap_read("decim", 1'b0);

        // Reset mid-capture: right channel, falling slope, starting from ARMED
        decim = 4'd0; ch_sel = 1'b1; trig_slope = 1'b1; trig_level = 8'sd0;
        feed(2, 364, -1, 1);
        check("mid_capture", 32'(state), 32'(2));
        rd_addr = 10'd5;
        @(negedge sysclk);
        check("pre_reset_front", 32'(rd_data), 32'(8'h94));
        do_reset("rst5");
        @(negedge sysclk);
        check("armed5", 32'(state), 32'(1));
        feed(2, 704, 64, 1);
        wait_state(2'd3, 20, "done_resume");
        swap_read("resume", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
